// File: rtl/trigger_period_monitor_if.sv
// Bus between a trigger source/controller and trigger_period_monitor.
// STATE is a debug view of the monitor FSM (0=IDLE, 1=ARMED, 2=MEASURE).
interface trigger_period_monitor_if #(
    parameter int PERIOD_WIDTH = 16
);
    // PERIOD_VALID is a one-cycle pulse with no ready/backpressure: PERIOD is
    // meaningful in that cycle and simply holds its value afterwards.
    logic                    ENABLE_IN;
    logic                    TRIG_IN;
    logic                    CLEAR;
    logic [PERIOD_WIDTH-1:0] PERIOD;
    logic                    PERIOD_VALID;
    logic                    PERIOD_ERR;
    logic                    TIMEOUT_ERR;
    logic                    LOCKED;
    logic [1:0]              STATE;

    modport master (
        output ENABLE_IN, TRIG_IN, CLEAR,
        input  PERIOD, PERIOD_VALID, PERIOD_ERR, TIMEOUT_ERR, LOCKED, STATE
    );

    modport slave (
        input  ENABLE_IN, TRIG_IN, CLEAR,
        output PERIOD, PERIOD_VALID, PERIOD_ERR, TIMEOUT_ERR, LOCKED, STATE
    );
endinterface

// File: rtl/trigger_period_monitor.sv
// Measures the interval between trigger pulses, flags out-of-window periods and
// reports lock. Optional trigger timeout enabled by defining TRIGMON_TIMEOUT_EN.
module trigger_period_monitor #(
    parameter int PERIOD_WIDTH = 16,
    parameter int PERIOD_MIN   = 4,
    parameter int PERIOD_MAX   = 6,
    parameter int LOCK_COUNT   = 3,
    parameter int TIMEOUT      = 64
) (
    input logic                    CLK,
    input logic                    RESET,
    trigger_period_monitor_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam int GOOD_WIDTH = $clog2(LOCK_COUNT + 1);
    localparam logic [PERIOD_WIDTH-1:0] MIN_P  = PERIOD_WIDTH'(PERIOD_MIN);
    localparam logic [PERIOD_WIDTH-1:0] MAX_P  = PERIOD_WIDTH'(PERIOD_MAX);
    localparam logic [GOOD_WIDTH-1:0]   LOCK_G = GOOD_WIDTH'(LOCK_COUNT);

    if (longint'(TIMEOUT) >= (longint'(1) << PERIOD_WIDTH)) begin : g_bad_timeout
        $error("TIMEOUT must be below 2**PERIOD_WIDTH");
    end

    state_t                  state;
    logic [PERIOD_WIDTH-1:0] interval;
    logic [PERIOD_WIDTH-1:0] period_q;
    logic [GOOD_WIDTH-1:0]   good;
    logic                    valid_q;
    logic                    perr_q;
    logic                    locked_q;
    logic                    in_window;
    logic [GOOD_WIDTH-1:0]   good_inc;

    always_comb begin
        in_window = (interval >= MIN_P) && (interval <= MAX_P);
        good_inc  = (good == LOCK_G) ? good : good + GOOD_WIDTH'(1);
    end

`ifdef TRIGMON_TIMEOUT_EN
    localparam logic [PERIOD_WIDTH-1:0] TIMEOUT_P = PERIOD_WIDTH'(TIMEOUT);
    logic terr_q;
`endif

    // interval restarts at 1 on each sampled trigger, so at the closing
    // trigger edge it already equals the edge distance between the two.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            interval <= '0;
            period_q <= '0;
            good     <= '0;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
            locked_q <= 1'b0;
`ifdef TRIGMON_TIMEOUT_EN
            terr_q   <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            if (bus.CLEAR) begin
                perr_q <= 1'b0;
`ifdef TRIGMON_TIMEOUT_EN
                terr_q <= 1'b0;
`endif
            end
            if (!bus.ENABLE_IN) begin
                state    <= IDLE;
                interval <= '0;
                good     <= '0;
                locked_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= ARMED;
                    ARMED: begin
                        if (bus.TRIG_IN) begin
                            state    <= MEASURE;
                            interval <= PERIOD_WIDTH'(1);
                        end
                    end
                    MEASURE: begin
                        if (bus.TRIG_IN) begin
                            period_q <= interval;
                            valid_q  <= 1'b1;
                            interval <= PERIOD_WIDTH'(1);
                            if (in_window) begin
                                good     <= good_inc;
                                locked_q <= (good_inc == LOCK_G);
                            end else begin
                                perr_q   <= 1'b1;
                                good     <= '0;
                                locked_q <= 1'b0;
                            end
`ifdef TRIGMON_TIMEOUT_EN
                        end else if (interval == TIMEOUT_P) begin
                            terr_q   <= 1'b1;
                            good     <= '0;
                            locked_q <= 1'b0;
                            interval <= '0;
                            state    <= ARMED;
`endif
                        end else if (interval != '1) begin
                            interval <= interval + PERIOD_WIDTH'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.PERIOD       = period_q;
    assign bus.PERIOD_VALID = valid_q;
    assign bus.PERIOD_ERR   = perr_q;
    assign bus.LOCKED       = locked_q;
    assign bus.STATE        = state;
`ifdef TRIGMON_TIMEOUT_EN
    assign bus.TIMEOUT_ERR  = terr_q;
`else
    assign bus.TIMEOUT_ERR  = 1'b0;
`endif
endmodule

// File: tb/tb_trigger_period_monitor.sv
// Self-checking bench for trigger_period_monitor: directed scenarios plus
// randomized trigger gaps checked against a timestamp-based reference model.
module tb_trigger_period_monitor;
  localparam int W       = 16;
  localparam int P_MIN   = 4;
  localparam int P_MAX   = 6;
  localparam int LOCK_N  = 3;
  localparam int TMO     = 64;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  trigger_period_monitor_if #(.PERIOD_WIDTH(W)) bus ();

  trigger_period_monitor #(
    .PERIOD_WIDTH(W), .PERIOD_MIN(P_MIN), .PERIOD_MAX(P_MAX),
    .LOCK_COUNT(LOCK_N), .TIMEOUT(TMO)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model: trigger timestamps, not an FSM
  int         cyc = 0;
  bit         m_armed, m_have_last;
  int         m_last, m_good;
  bit         m_locked, m_perr, m_terr, m_valid;
  logic [W-1:0] m_period;
  logic [W-1:0] exp_q[$];

  task automatic model_reset();
    m_armed = 0; m_have_last = 0; m_good = 0; m_locked = 0;
    m_perr = 0; m_terr = 0; m_valid = 0; m_period = '0;
    exp_q.delete();
  endtask

  // one clock edge with the given TRIG_IN/CLEAR, model advanced, ends at negedge
  task automatic step(input bit trig, input bit clr);
    int p;
    bit new_err, new_terr;
    bus.TRIG_IN = trig;
    bus.CLEAR = clr;
    @(posedge CLK);
    cyc++;
    m_valid = 0; new_err = 0; new_terr = 0;
    if (!bus.ENABLE_IN) begin
      m_armed = 0; m_have_last = 0; m_good = 0; m_locked = 0;
    end else if (!m_armed) begin
      m_armed = 1;
    end else if (trig) begin
      if (m_have_last) begin
        p = cyc - m_last;
        m_valid = 1;
        m_period = p[W-1:0];
        exp_q.push_back(m_period);
        if (p >= P_MIN && p <= P_MAX) begin
          if (m_good < LOCK_N) m_good++;
        end else begin
          new_err = 1; m_good = 0;
        end
        m_locked = (m_good == LOCK_N);
      end
      m_have_last = 1;
      m_last = cyc;
    end
`ifdef TRIGMON_TIMEOUT_EN
    else if (m_have_last && (cyc - m_last) == TMO) begin
      new_terr = 1; m_good = 0; m_locked = 0; m_have_last = 0;
    end
`endif
    if (new_err) m_perr = 1; else if (clr) m_perr = 0;
    if (new_terr) m_terr = 1; else if (clr) m_terr = 0;
    @(negedge CLK);
    bus.TRIG_IN = 1'b0;
    bus.CLEAR = 1'b0;
  endtask

  task automatic restart();
    bus.ENABLE_IN = 1'b0;
    step(0, 1);
    bus.ENABLE_IN = 1'b1;
    step(0, 0);
  endtask

  // scoreboard: every VALID pulse must match the next expected period
  always @(negedge CLK) begin
    if (!RESET && bus.PERIOD_VALID === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected_valid: got PERIOD=%0d, required no VALID", bus.PERIOD);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (bus.PERIOD !== e) begin
          tests_failed++;
          $display("FAIL sb_period: got %0d, required %0d", bus.PERIOD, e);
        end
      end
    end
  end

  task automatic test_reset();
    #1;
    tests_run++;
    if ({bus.PERIOD, bus.PERIOD_VALID, bus.PERIOD_ERR, bus.TIMEOUT_ERR, bus.LOCKED} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got P=%0d V=%b E=%b T=%b L=%b, required all 0",
               bus.PERIOD, bus.PERIOD_VALID, bus.PERIOD_ERR, bus.TIMEOUT_ERR, bus.LOCKED);
    end
    tests_run++;
    if (bus.STATE !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d, required 0", bus.STATE);
    end
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    model_reset();
  endtask

  task automatic test_lock();
    restart();
    for (int i = 0; i < 5; i++) begin
      step(1, 0);
      tests_run++;
      if (bus.PERIOD_VALID !== (i > 0)) begin
        tests_failed++;
        $display("FAIL lock_valid[%0d]: got %b, required %b", i, bus.PERIOD_VALID, i > 0);
      end
      if (i > 0) begin
        tests_run++;
        if (bus.PERIOD !== 16'd5) begin
          tests_failed++;
          $display("FAIL lock_period[%0d]: got %0d, required 5", i, bus.PERIOD);
        end
      end
      tests_run++;
      if (bus.LOCKED !== (i >= 3)) begin
        tests_failed++;
        $display("FAIL lock_locked[%0d]: got %b, required %b", i, bus.LOCKED, i >= 3);
      end
      tests_run++;
      if (bus.PERIOD_ERR !== 1'b0 || bus.TIMEOUT_ERR !== 1'b0) begin
        tests_failed++;
        $display("FAIL lock_errors[%0d]: got E=%b T=%b, required 0 0", i, bus.PERIOD_ERR, bus.TIMEOUT_ERR);
      end
      repeat (4) step(0, 0);
    end
  endtask

  task automatic test_gap_error();
    restart();
    for (int i = 0; i < 4; i++) begin
      step(1, 0);
      repeat (4) step(0, 0);
    end
    repeat (3) step(0, 0);
    step(1, 0);
    tests_run++;
    if (bus.PERIOD !== 16'd8 || bus.PERIOD_ERR !== 1'b1 || bus.LOCKED !== 1'b0) begin
      tests_failed++;
      $display("FAIL gap_error: got P=%0d E=%b L=%b, required P=8 E=1 L=0",
               bus.PERIOD, bus.PERIOD_ERR, bus.LOCKED);
    end
    for (int i = 0; i < 3; i++) begin
      repeat (4) step(0, 0);
      step(1, 0);
    end
    tests_run++;
    if (bus.LOCKED !== 1'b1 || bus.PERIOD_ERR !== 1'b1) begin
      tests_failed++;
      $display("FAIL gap_relock: got L=%b E=%b, required L=1 E=1", bus.LOCKED, bus.PERIOD_ERR);
    end
  endtask

  task automatic test_back_to_back();
    restart();
    step(1, 0);
    step(1, 0);
    tests_run++;
    if (bus.PERIOD_VALID !== 1'b1 || bus.PERIOD !== 16'd1 || bus.PERIOD_ERR !== 1'b1) begin
      tests_failed++;
      $display("FAIL back_to_back: got V=%b P=%0d E=%b, required V=1 P=1 E=1",
               bus.PERIOD_VALID, bus.PERIOD, bus.PERIOD_ERR);
    end
  endtask

  task automatic test_clear();
    restart();
    tests_run++;
    if (bus.PERIOD_ERR !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_initial: got %b, required 0", bus.PERIOD_ERR);
    end
    step(1, 0);
    repeat (8) step(0, 0);
    step(1, 1);
    tests_run++;
    if (bus.PERIOD !== 16'd9 || bus.PERIOD_ERR !== 1'b1) begin
      tests_failed++;
      $display("FAIL clear_vs_error: got P=%0d E=%b, required P=9 E=1", bus.PERIOD, bus.PERIOD_ERR);
    end
    step(0, 1);
    tests_run++;
    if (bus.PERIOD_ERR !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_alone: got %b, required 0", bus.PERIOD_ERR);
    end
  endtask

  task automatic test_idle_ignore();
    restart();
    step(1, 0);
    repeat (4) step(0, 0);
    step(1, 0);
    bus.ENABLE_IN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1, 0);
      tests_run++;
      if (bus.STATE !== 2'd0 || bus.PERIOD_VALID !== 1'b0 || bus.PERIOD !== 16'd5 || bus.LOCKED !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle_ignore[%0d]: got S=%0d V=%b P=%0d L=%b, required S=0 V=0 P=5 L=0",
                 i, bus.STATE, bus.PERIOD_VALID, bus.PERIOD, bus.LOCKED);
      end
    end
    bus.ENABLE_IN = 1'b1;
    step(1, 0);
    step(1, 0);
    tests_run++;
    if (bus.PERIOD_VALID !== 1'b0 || bus.STATE !== 2'd2) begin
      tests_failed++;
      $display("FAIL idle_rearm: got V=%b S=%0d, required V=0 S=2", bus.PERIOD_VALID, bus.STATE);
    end
    repeat (5) step(0, 0);
    step(1, 0);
    tests_run++;
    if (bus.PERIOD !== 16'd6 || bus.PERIOD_VALID !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_resume: got P=%0d V=%b, required P=6 V=1", bus.PERIOD, bus.PERIOD_VALID);
    end
  endtask

`ifdef TRIGMON_TIMEOUT_EN
  task automatic test_timeout();
    restart();
    for (int i = 0; i < 4; i++) begin
      step(1, 0);
      if (i < 3) repeat (4) step(0, 0);
    end
    tests_run++;
    if (bus.LOCKED !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_prelock: got %b, required 1", bus.LOCKED);
    end
    repeat (TMO - 1) step(0, 0);
    tests_run++;
    if (bus.TIMEOUT_ERR !== 1'b0 || bus.STATE !== 2'd2) begin
      tests_failed++;
      $display("FAIL timeout_early: got T=%b S=%0d, required T=0 S=2", bus.TIMEOUT_ERR, bus.STATE);
    end
    step(0, 0);
    tests_run++;
    if (bus.TIMEOUT_ERR !== 1'b1 || bus.LOCKED !== 1'b0 || bus.STATE !== 2'd1) begin
      tests_failed++;
      $display("FAIL timeout_fire: got T=%b L=%b S=%0d, required T=1 L=0 S=1",
               bus.TIMEOUT_ERR, bus.LOCKED, bus.STATE);
    end
    step(1, 0);
    tests_run++;
    if (bus.PERIOD_VALID !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_next_trig: got V=%b, required 0", bus.PERIOD_VALID);
    end
    step(0, 1);
  endtask
`else
  task automatic test_long_gap();
    restart();
    step(1, 0);
    repeat (69) step(0, 0);
    tests_run++;
    if (bus.STATE !== 2'd2 || bus.TIMEOUT_ERR !== 1'b0) begin
      tests_failed++;
      $display("FAIL long_gap_state: got S=%0d T=%b, required S=2 T=0", bus.STATE, bus.TIMEOUT_ERR);
    end
    step(1, 0);
    tests_run++;
    if (bus.PERIOD !== 16'd70 || bus.PERIOD_VALID !== 1'b1 || bus.PERIOD_ERR !== 1'b1) begin
      tests_failed++;
      $display("FAIL long_gap_period: got P=%0d V=%b E=%b, required P=70 V=1 E=1",
               bus.PERIOD, bus.PERIOD_VALID, bus.PERIOD_ERR);
    end
  endtask
`endif

  task automatic test_async_reset();
    restart();
    step(1, 0);
    step(1, 0);
    repeat (2) step(0, 0);
    #2 RESET = 1'b1;
    #1;
    tests_run++;
    if ({bus.PERIOD, bus.PERIOD_VALID, bus.PERIOD_ERR, bus.TIMEOUT_ERR, bus.LOCKED} !== '0 ||
        bus.STATE !== 2'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got P=%0d V=%b E=%b T=%b L=%b S=%0d, required all 0",
               bus.PERIOD, bus.PERIOD_VALID, bus.PERIOD_ERR, bus.TIMEOUT_ERR, bus.LOCKED, bus.STATE);
    end
    #1 RESET = 1'b0;
    model_reset();
    step(0, 0);
    step(1, 0);
    tests_run++;
    if (bus.PERIOD_VALID !== 1'b0 || bus.STATE !== 2'd2) begin
      tests_failed++;
      $display("FAIL async_reset_first_trig: got V=%b S=%0d, required V=0 S=2",
               bus.PERIOD_VALID, bus.STATE);
    end
  endtask

  task automatic test_random();
    int gap;
    restart();
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        bus.ENABLE_IN = 1'b0;
        step(0, 0);
        bus.ENABLE_IN = 1'b1;
      end
      if ($urandom_range(0, 3) != 0) gap = $urandom_range(P_MIN, P_MAX);
      else gap = $urandom_range(1, 10);
      for (int c = 0; c < gap; c++) begin
        step(c == 0, $urandom_range(0, 7) == 0);
        tests_run++;
        if (bus.PERIOD_VALID !== m_valid || bus.PERIOD !== m_period || bus.LOCKED !== m_locked ||
            bus.PERIOD_ERR !== m_perr || bus.TIMEOUT_ERR !== m_terr) begin
          tests_failed++;
          $display("FAIL random[%0d.%0d]: got V=%b P=%0d L=%b E=%b T=%b, required V=%b P=%0d L=%b E=%b T=%b",
                   n, c, bus.PERIOD_VALID, bus.PERIOD, bus.LOCKED, bus.PERIOD_ERR, bus.TIMEOUT_ERR,
                   m_valid, m_period, m_locked, m_perr, m_terr);
        end
      end
    end
  endtask

  initial begin
    bus.ENABLE_IN = 1'b0;
    bus.TRIG_IN = 1'b0;
    bus.CLEAR = 1'b0;
    model_reset();
    test_reset();
    test_lock();
    test_gap_error();
    test_back_to_back();
    test_clear();
    test_idle_ignore();
`ifdef TRIGMON_TIMEOUT_EN
    test_timeout();
`else
    test_long_gap();
`endif
    test_async_reset();
    test_random();
    repeat (2) step(0, 0);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drain: got %0d periods never reported, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
